// File: rtl/symcounter_pkg.sv
// Shared types and constants for the symbol-counter game: answer FSM states and
// active-low seven-segment patterns (bit7..bit1 = CA..CG, bit0 = DP).
package symcounter_pkg;

  typedef enum logic [1:0] {
    ANS_IDLE   = 2'd0,
    ANS_ENTRY  = 2'd1,
    ANS_CHECK  = 2'd2,
    ANS_RESULT = 2'd3
  } answer_state_t;

  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern, decimal point off.
module hex_to_seg
  import symcounter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/answer_check.sv
// Answer entry and scoring stage: latches the special-symbol count, takes a guess via
// up/down/submit, reports correct/wrong/timeout. Optional macro: ANSWER_TIMEOUT_EN.
module answer_check
  import symcounter_pkg::*;
#(
  parameter int ANSWER_SECS = 10,
  parameter int RESULT_SECS = 3
) (
  input  logic       Clk100M,
  input  logic       Rst,
  input  logic       secTick,
  input  logic       stopGen,
  input  logic [7:0] numSpecial,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnSubmit,
  output logic [7:0] guess,
  output logic [7:0] guessSeg0,
  output logic [7:0] guessSeg1,
  output logic       entryActive,
  output logic       correct,
  output logic       wrong,
  output logic       timedOut,
  output logic       answerDone,
  output logic [7:0] score
);

  localparam logic [7:0] ANSWER_LOAD = 8'(ANSWER_SECS);
  localparam logic [7:0] RESULT_LOAD = 8'(RESULT_SECS);

  answer_state_t state_r, state_s;
  logic [7:0] guess_r, guess_s, target_r, target_s, score_r, score_s;
  logic [7:0] remain_r, remain_s;
  logic       correct_r, correct_s, wrong_r, wrong_s, timedout_r, timedout_s;
  logic       done_r, done_s, entry_r;
  logic       up_prev_r, down_prev_r, submit_prev_r;
  logic [7:0] seg0_r, seg1_r, seg0_s, seg1_s;
  logic       up_edge_s, down_edge_s, submit_edge_s;

  assign up_edge_s     = btnUp & ~up_prev_r;
  assign down_edge_s   = btnDown & ~down_prev_r;
  assign submit_edge_s = btnSubmit & ~submit_prev_r;

  hex_to_seg u_seg0 (.nibble(guess_r[3:0]), .seg(seg0_s));
  hex_to_seg u_seg1 (.nibble(guess_r[7:4]), .seg(seg1_s));

  // Next-state and next-value logic for the answer FSM
  always_comb begin
    state_s    = state_r;
    guess_s    = guess_r;
    target_s   = target_r;
    score_s    = score_r;
    remain_s   = remain_r;
    correct_s  = correct_r;
    wrong_s    = wrong_r;
    timedout_s = timedout_r;
    done_s     = 1'b0;
    case (state_r)
      ANS_IDLE: begin
        if (stopGen) begin
          target_s = numSpecial;
          guess_s  = 8'd0;
          remain_s = ANSWER_LOAD;
          state_s  = ANS_ENTRY;
        end else begin
          state_s = ANS_IDLE;
        end
      end
      ANS_ENTRY: begin
        if (submit_edge_s) begin
          state_s = ANS_CHECK;
        end else begin
          if (up_edge_s && !down_edge_s && guess_r != 8'hFF) begin
            guess_s = guess_r + 8'd1;
          end else if (down_edge_s && !up_edge_s && guess_r != 8'h00) begin
            guess_s = guess_r - 8'd1;
          end else begin
            guess_s = guess_r;
          end
`ifdef ANSWER_TIMEOUT_EN
          if (secTick) begin
            if (remain_r == 8'd1) begin
              timedout_s = 1'b1;
              remain_s   = RESULT_LOAD;
              state_s    = ANS_RESULT;
            end else begin
              remain_s = remain_r - 8'd1;
            end
          end else begin
            remain_s = remain_r;
          end
`endif
        end
      end
      ANS_CHECK: begin
        if (guess_r == target_r) begin
          correct_s = 1'b1;
          score_s   = (score_r == 8'hFF) ? score_r : score_r + 8'd1;
        end else begin
          wrong_s = 1'b1;
        end
        remain_s = RESULT_LOAD;
        state_s  = ANS_RESULT;
      end
      ANS_RESULT: begin
        if (secTick) begin
          if (remain_r == 8'd1) begin
            done_s     = 1'b1;
            correct_s  = 1'b0;
            wrong_s    = 1'b0;
            timedout_s = 1'b0;
            state_s    = ANS_IDLE;
          end else begin
            remain_s = remain_r - 8'd1;
          end
        end else begin
          remain_s = remain_r;
        end
      end
      default: begin
        correct_s  = 1'b0;
        wrong_s    = 1'b0;
        timedout_s = 1'b0;
        state_s    = ANS_IDLE;
      end
    endcase
  end

  // State and output registers, including the registered segment patterns
  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      state_r       <= ANS_IDLE;
      guess_r       <= 8'd0;
      target_r      <= 8'd0;
      score_r       <= 8'd0;
      remain_r      <= 8'd0;
      correct_r     <= 1'b0;
      wrong_r       <= 1'b0;
      timedout_r    <= 1'b0;
      done_r        <= 1'b0;
      entry_r       <= 1'b0;
      up_prev_r     <= 1'b0;
      down_prev_r   <= 1'b0;
      submit_prev_r <= 1'b0;
      seg0_r        <= SEG_HEX[0];
      seg1_r        <= SEG_HEX[0];
    end else begin
      state_r       <= state_s;
      guess_r       <= guess_s;
      target_r      <= target_s;
      score_r       <= score_s;
      remain_r      <= remain_s;
      correct_r     <= correct_s;
      wrong_r       <= wrong_s;
      timedout_r    <= timedout_s;
      done_r        <= done_s;
      entry_r       <= (state_s == ANS_ENTRY);
      up_prev_r     <= btnUp;
      down_prev_r   <= btnDown;
      submit_prev_r <= btnSubmit;
      seg0_r        <= seg0_s;
      seg1_r        <= seg1_s;
    end
  end

  assign guess       = guess_r;
  assign guessSeg0   = seg0_r;
  assign guessSeg1   = seg1_r;
  assign entryActive = entry_r;
  assign correct     = correct_r;
  assign wrong       = wrong_r;
  assign timedOut    = timedout_r;
  assign answerDone  = done_r;
  assign score       = score_r;

endmodule

// File: tb/tb_answer_check.sv
// Self-checking bench for answer_check; round results are scoreboarded.
module tb_answer_check;

  logic       Clk100M = 1'b0;
  logic       Rst = 1'b1;
  logic       secTick = 1'b0, stopGen = 1'b0;
  logic [7:0] numSpecial = 8'd0;
  logic       btnUp = 1'b0, btnDown = 1'b0, btnSubmit = 1'b0;
  logic [7:0] guess, guessSeg0, guessSeg1, score;
  logic       entryActive, correct, wrong, timedOut, answerDone;

  typedef struct {
    logic       c;
    logic       w;
    logic       t;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] mscore = 8'd0;
  logic [7:0] mtarget = 8'd0;

  answer_check dut (
    .Clk100M(Clk100M), .Rst(Rst), .secTick(secTick), .stopGen(stopGen),
    .numSpecial(numSpecial), .btnUp(btnUp), .btnDown(btnDown), .btnSubmit(btnSubmit),
    .guess(guess), .guessSeg0(guessSeg0), .guessSeg1(guessSeg1),
    .entryActive(entryActive), .correct(correct), .wrong(wrong), .timedOut(timedOut),
    .answerDone(answerDone), .score(score)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk100M);
      #1;
    end
  endtask

  task automatic press(input logic up, input logic dn);
    btnUp = up; btnDown = dn;
    cyc(1);
    btnUp = 1'b0; btnDown = 1'b0;
    cyc(1);
  endtask

  task automatic start_round(input logic [7:0] n);
    numSpecial = n; stopGen = 1'b1;
    cyc(1);
    stopGen = 1'b0;
    mtarget = n;
    checks++;
    if (entryActive !== 1'b1 || guess !== 8'd0) begin
      failures++;
      $display("FAIL start_round: entryActive=%b guess=%0d, required 1 and 0", entryActive, guess);
    end
  endtask

  // Push expected result for a submitted guess, then check the 2-cycle latency.
  task automatic submit(input logic [7:0] g, input logic up_too, input logic tick_too);
    exp_t e;
    exp_t got;
    e.c = (g == mtarget); e.w = (g != mtarget); e.t = 1'b0;
    if (e.c && mscore != 8'hFF) mscore = mscore + 8'd1;
    e.sc = mscore;
    sb.push_back(e);
    btnSubmit = 1'b1; btnUp = up_too; secTick = tick_too;
    cyc(1);
    btnSubmit = 1'b0; btnUp = 1'b0; secTick = 1'b0;
    checks++;
    if ((correct | wrong | timedOut) !== 1'b0) begin
      failures++;
      $display("FAIL check_cycle_flags: c/w/t=%b%b%b, required 000", correct, wrong, timedOut);
    end
    cyc(1);
    got = sb.pop_front();
    checks++;
    if (correct !== got.c || wrong !== got.w || timedOut !== got.t || score !== got.sc) begin
      failures++;
      $display("FAIL result: c/w/t=%b%b%b score=%0d, required %b%b%b score=%0d",
               correct, wrong, timedOut, score, got.c, got.w, got.t, got.sc);
    end
  endtask

  task automatic finish_result();
    int dones = 0;
    for (int i = 0; i < 3; i++) begin
      secTick = 1'b1;
      cyc(1);
      secTick = 1'b0;
      if (answerDone === 1'b1) dones++;
      cyc(1);
      if (answerDone === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || (correct | wrong | timedOut) !== 1'b0 || entryActive !== 1'b0) begin
      failures++;
      $display("FAIL finish_result: dones=%0d c/w/t=%b%b%b entry=%b, required 1 000 0",
               dones, correct, wrong, timedOut, entryActive);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (guess !== 8'd0 || score !== 8'd0 || entryActive !== 1'b0 || answerDone !== 1'b0 ||
        (correct | wrong | timedOut) !== 1'b0 || guessSeg0 !== 8'h03 || guessSeg1 !== 8'h03) begin
      failures++;
      $display("FAIL reset: guess=%0d score=%0d entry=%b seg=%h/%h, required 0 0 0 03/03",
               guess, score, entryActive, guessSeg0, guessSeg1);
    end
  endtask

  task automatic test_correct();
    start_round(8'd5);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    checks++;
    if (guess !== 8'd5 || guessSeg0 !== 8'h49 || guessSeg1 !== 8'h03) begin
      failures++;
      $display("FAIL correct_guess: guess=%0d seg=%h/%h, required 5 49/03", guess, guessSeg1, guessSeg0);
    end
    submit(8'd5, 1'b0, 1'b0);
    finish_result();
  endtask

  task automatic test_wrong();
    start_round(8'd3);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    submit(8'd4, 1'b0, 1'b0);
    finish_result();
  endtask

  task automatic test_simultaneous();
    start_round(8'd2);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    checks++;
    if (guess !== 8'd2) begin
      failures++;
      $display("FAIL up_down_together: guess=%0d, required 2", guess);
    end
    submit(8'd2, 1'b1, 1'b0);
    checks++;
    if (guess !== 8'd2) begin
      failures++;
      $display("FAIL submit_up_together: guess=%0d, required 2", guess);
    end
    numSpecial = 8'd50; stopGen = 1'b1;
    cyc(1);
    stopGen = 1'b0;
    cyc(1);
    checks++;
    if (entryActive !== 1'b0 || correct !== 1'b1 || guess !== 8'd2) begin
      failures++;
      $display("FAIL stopgen_in_result: entry=%b correct=%b guess=%0d, required 0 1 2",
               entryActive, correct, guess);
    end
    finish_result();
  endtask

  task automatic test_saturation();
    start_round(8'd255);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    checks++;
    if (guess !== 8'd0) begin
      failures++;
      $display("FAIL sat_low: guess=%0d, required 0", guess);
    end
    for (int i = 0; i < 260; i++) press(1'b1, 1'b0);
    checks++;
    if (guess !== 8'd255 || guessSeg0 !== 8'h71 || guessSeg1 !== 8'h71) begin
      failures++;
      $display("FAIL sat_high: guess=%0d seg=%h/%h, required 255 71/71", guess, guessSeg1, guessSeg0);
    end
    submit(8'd255, 1'b0, 1'b0);
    finish_result();
  endtask

`ifdef ANSWER_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    start_round(8'd9);
    for (int i = 0; i < 9; i++) begin
      secTick = 1'b1; cyc(1); secTick = 1'b0; cyc(1);
    end
    checks++;
    if (timedOut !== 1'b0 || entryActive !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: timedOut=%b entry=%b, required 0 1", timedOut, entryActive);
    end
    e.c = 1'b0; e.w = 1'b0; e.t = 1'b1; e.sc = mscore;
    sb.push_back(e);
    secTick = 1'b1; cyc(1); secTick = 1'b0;
    e = sb.pop_front();
    checks++;
    if (timedOut !== e.t || correct !== e.c || wrong !== e.w || score !== e.sc) begin
      failures++;
      $display("FAIL timeout: c/w/t=%b%b%b score=%0d, required 001 score=%0d",
               correct, wrong, timedOut, score, e.sc);
    end
    cyc(1);
    finish_result();
    start_round(8'd0);
    for (int i = 0; i < 9; i++) begin
      secTick = 1'b1; cyc(1); secTick = 1'b0; cyc(1);
    end
    submit(8'd0, 1'b0, 1'b1);
    finish_result();
  endtask
`endif

  task automatic test_reset_midround();
    int dones = 0;
    start_round(8'd9);
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0);
    Rst = 1'b1;
    cyc(1);
    if (answerDone === 1'b1) dones++;
    checks++;
    if (entryActive !== 1'b0 || guess !== 8'd0 || score !== 8'd0 ||
        guessSeg0 !== 8'h03 || guessSeg1 !== 8'h03 || dones != 0) begin
      failures++;
      $display("FAIL reset_midround: entry=%b guess=%0d score=%0d seg=%h/%h dones=%0d, required 0 0 0 03/03 0",
               entryActive, guess, score, guessSeg1, guessSeg0, dones);
    end
    Rst = 1'b0;
    mscore = 8'd0;
    cyc(2);
    checks++;
    if (answerDone !== 1'b0 || entryActive !== 1'b0) begin
      failures++;
      $display("FAIL reset_after: answerDone=%b entry=%b, required 0 0", answerDone, entryActive);
    end
  endtask

  initial begin
    Rst = 1'b1;
    cyc(2);
    test_reset();
    Rst = 1'b0;
    cyc(1);
    test_correct();
    test_wrong();
    test_simultaneous();
    test_saturation();
`ifdef ANSWER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midround();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
